// File: rtl/fxp_div_pkg.sv
// Shared definitions for the fixed-point divider request controller:
// controller state encoding and the saturation limits of an N-bit word.
package fxp_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_CLR,
    WAIT_DONE,
    RESP
  } state_e;

  // Largest magnitude representable in an N-bit sign-magnitude word
  // (2^(N-1)-1), returned as a two's-complement value in 64 bits.
  function automatic logic [63:0] sm_max_pos(input int unsigned n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Negative counterpart -(2^(N-1)-1), two's complement in 64 bits.
  function automatic logic [63:0] sm_max_neg(input int unsigned n);
    return ~sm_max_pos(n) + 64'd1;
  endfunction

endpackage

// File: rtl/fxp_tc2sm.sv
// Combinational two's-complement to sign-magnitude converter.
// -2^(N-1) has no sign-magnitude image; it is clamped to -(2^(N-1)-1)
// and reported on ovf_o.
module fxp_tc2sm
  import fxp_div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] tc_i,
  output logic [N-1:0] sm_o,
  output logic         ovf_o
);

  logic [N-2:0] mag_neg;

  // Sign bit passes through; negative values take the negated low bits.
  always_comb begin
    mag_neg = ~tc_i[N-2:0] + (N-1)'(1);
    ovf_o   = 1'b0;
    if (!tc_i[N-1]) begin
      sm_o = tc_i;
    end else if (tc_i[N-2:0] == '0) begin
      sm_o  = '1;
      ovf_o = 1'b1;
    end else begin
      sm_o = {1'b1, mag_neg};
    end
  end

endmodule

// File: rtl/fxp_div_req_ctrl.sv
// Request/response controller around a sign-magnitude fixed-point divider.
// Converts two's-complement operands to sign-magnitude, runs the divider's
// start/complete handshake, converts the quotient back and returns it.
// Divide-by-zero is answered directly with a saturated quotient.
// Optional watchdog: define FXP_DIV_TIMEOUT_EN to abort waits on the
// divider after TIMEOUT_CYCLES cycles (out_timeout is tied low otherwise).
module fxp_div_req_ctrl
  import fxp_div_pkg::*;
#(
  parameter int N              = 32,
  parameter int Q              = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_dividend,
  input  logic [N-1:0] in_divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_quotient,
  output logic         out_dbz,
  output logic         out_ovf,
  output logic         out_timeout,
  output logic         div_start,
  output logic [N-1:0] div_dividend,
  output logic [N-1:0] div_divisor,
  input  logic [N-1:0] div_quotient,
  input  logic         div_complete,
  output logic         busy
);

  // Q only documents the operand format; the controller is scale-free.
  if (N < 2 || N > 64 || Q < 0 || Q >= N || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("fxp_div_req_ctrl: parameter out of range");
  end

  localparam logic [63:0]  MAX_POS_64 = sm_max_pos(N);
  localparam logic [63:0]  MAX_NEG_64 = sm_max_neg(N);
  localparam logic [N-1:0] SM_MAX_POS = MAX_POS_64[N-1:0];
  localparam logic [N-1:0] SM_MAX_NEG = MAX_NEG_64[N-1:0];

  state_e       state_q, state_d;
  logic [N-1:0] dvd_q, dvd_d, dvs_q, dvs_d, quot_q, quot_d;
  logic         dbz_q, dbz_d, ovf_q, ovf_d;
  logic [N-1:0] dvd_sm, dvs_sm, q_mag;
  logic         dvd_ovf, dvs_ovf;

`ifdef FXP_DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  fxp_tc2sm #(.N(N)) u_dvd_conv (
    .tc_i  (in_dividend),
    .sm_o  (dvd_sm),
    .ovf_o (dvd_ovf)
  );

  fxp_tc2sm #(.N(N)) u_dvs_conv (
    .tc_i  (in_divisor),
    .sm_o  (dvs_sm),
    .ovf_o (dvs_ovf)
  );

  assign q_mag = {1'b0, div_quotient[N-2:0]};

  // Next-state and datapath-capture logic for the request sequence.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
`ifdef FXP_DIV_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = dvd_sm;
          dvs_d = dvs_sm;
          ovf_d = dvd_ovf | dvs_ovf;
          dbz_d = (dvs_sm[N-2:0] == '0);
`ifdef FXP_DIV_TIMEOUT_EN
          to_d  = 1'b0;
`endif
          if (dvs_sm[N-2:0] == '0) begin
            // Zero divisor: answer immediately, divider stays idle.
            quot_d  = in_dividend[N-1] ? SM_MAX_NEG : SM_MAX_POS;
            state_d = RESP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
`ifdef FXP_DIV_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        // A complete still high here belongs to the previous operation.
        if (!div_complete) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (div_complete) begin
          // Negating a zero magnitude yields 0, so negative zero vanishes.
          quot_d  = div_quotient[N-1] ? (~q_mag + N'(1)) : q_mag;
          state_d = RESP;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef FXP_DIV_TIMEOUT_EN
    if ((state_q == WAIT_CLR || state_q == WAIT_DONE) && state_d == state_q) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
        state_d = RESP;
        quot_d  = '0;
        to_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  // State and operand/result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef FXP_DIV_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
`ifdef FXP_DIV_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // Handshake outputs decode straight from state, so reset clears them at once.
  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == RESP);
  assign div_start    = (state_q == LOAD);
  assign busy         = (state_q != IDLE);
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign out_quotient = quot_q;
  assign out_dbz      = dbz_q;
  assign out_ovf      = ovf_q;
`ifdef FXP_DIV_TIMEOUT_EN
  assign out_timeout  = to_q;
`else
  assign out_timeout  = 1'b0;
`endif

endmodule

// File: doc/fxp_div_req_ctrl.md
Name: fxp_div_req_ctrl

Overview:
- Front-end/back-end stage wrapped around the sign-magnitude fixed-point divider top.
- Accepts two's-complement Qm.Q operand pairs over a valid/ready handshake and converts them to sign-magnitude (bit N-1 = sign, bits N-2:0 = magnitude).
- Sequences the divider's start/complete protocol, converts the sign-magnitude quotient back to two's complement, and returns it over valid/ready.
- Short-circuits divide-by-zero and flags unrepresentable inputs.

Parameters:
- N, 32, word width of operands and quotient.
- Q, 3, fractional bits. Pass-through only: the block does no scaling.
- TIMEOUT_CYCLES, 255, watchdog limit. Used only when FXP_DIV_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, all state rising-edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_dividend  in  N  two's-complement dividend.
- in_divisor  in  N  two's-complement divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_quotient  out  N  two's-complement quotient.
- out_dbz  out  1  divisor was zero.
- out_ovf  out  1  an input was -2^(N-1) and was clamped.
- out_timeout  out  1  watchdog fired. Tied 0 without the macro.
- div_start  out  1  divider start.
- div_dividend  out  N  sign-magnitude dividend to divider.
- div_divisor  out  N  sign-magnitude divisor to divider.
- div_quotient  in  N  sign-magnitude quotient from divider.
- div_complete  in  1  divider done (level).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE. Outputs: in_ready=1, out_valid=0, all flags 0, div_start=0, div_dividend=0, div_divisor=0, out_quotient=0.
- IDLE:
  - in_ready=1. Capture operands on in_valid&in_ready.
  - Convert each operand: sign = bit N-1; magnitude = sign ? -x : x.
  - x = -2^(N-1): magnitude = 2^(N-1)-1, ovf=1.
  - Divisor magnitude 0 goes to RESP directly. The divider is not started. out_quotient = dividend sign ? -(2^(N-1)-1) : 2^(N-1)-1; dbz=1.
  - Otherwise go to LOAD.
- LOAD:
  - div_start=1 for exactly one cycle; div_dividend/div_divisor already registered and held stable until RESP.
  - Go to WAIT_CLR.
- WAIT_CLR: wait for div_complete==0, which rejects a stale complete from the previous operation. Then go to WAIT_DONE.
- WAIT_DONE:
  - On div_complete==1, register the quotient. out_quotient = div_quotient[N-1] ? -{0,div_quotient[N-2:0]} : {0,div_quotient[N-2:0]}.
  - Negative zero maps to 0.
  - Go to RESP.
- RESP:
  - out_valid=1; out_quotient and flags held stable until out_valid&out_ready, then go to IDLE with out_valid=0.
  - in_ready=0 in all states except IDLE, so there are no back-to-back accepts. A new operand is accepted no earlier than the cycle after the response handshake.
- Latency: accept-to-out_valid = 3 cycles + divider latency. Divide-by-zero path = 1 cycle.
- Reset mid-operation: immediate return to IDLE; div_start drops asynchronously; any pending result is discarded.
- in_valid in a non-IDLE state: ignored and not captured.
- Flags are sticky for one transaction only and are cleared on the accept of the next operand pair.

Optional Feature:
- Macro: FXP_DIV_TIMEOUT_EN.
- Defined: an 8+-bit counter (width clog2(TIMEOUT_CYCLES+1)) runs in WAIT_CLR and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES, go to RESP with out_quotient=0 and out_timeout=1.
  - Counter clears in LOAD.
- Undefined: no counter; out_timeout constant 0; WAIT states wait indefinitely.

Decomposition:
- Shared package fxp_div_pkg:
  - State enum: IDLE, LOAD, WAIT_CLR, WAIT_DONE, RESP.
  - Constants SM_MAX_POS and SM_MAX_NEG as functions of N.
- One sub-module, fxp_tc2sm: combinational two's-complement-to-sign-magnitude converter with ovf output. Instantiated twice, for dividend and divisor.
- Reverse conversion stays inline.

Test Plan (N=32, Q=3, behavioural divider model with 40-cycle latency):
1. in_dividend=160 (20.0), in_divisor=40 (5.0). Expect div_dividend=0x000000A0, div_divisor=0x00000028, a single-cycle div_start; model returns 0x00000020; then out_quotient=32 (4.0), all flags 0.
2. in_dividend=-160, in_divisor=40. Expect div_dividend=0x800000A0; model returns 0x80000020; then out_quotient=0xFFFFFFE0 (-4.0).
3. in_dividend=-160, in_divisor=0. Expect no div_start; out_valid 1 cycle after accept; out_quotient=0x80000001, out_dbz=1.
4. in_dividend=0x80000000, in_divisor=8. Expect div_dividend=0xFFFFFFFF, out_ovf=1.
5. Hold out_ready=0 for 10 cycles after out_valid. Expect out_quotient stable, in_ready=0 throughout; accept on first out_ready=1, then in_ready=1 the next cycle.
6. Assert rst for 1 cycle during WAIT_DONE. Expect immediate IDLE, out_valid=0, div_start=0; the next operation completes correctly. With FXP_DIV_TIMEOUT_EN and the model never completing: out_timeout=1 after 255 cycles.
